// File: rtl/note_scheduler.sv
// Chart-driven note launcher and score keeper for the four lane droppers.
// Latency: launch/chart_addr one edge after the launch condition; score/combo one edge after an event.
// Backpressure: none; the dropper bank accepts every launch pulse, events are consumed every frame.
module note_scheduler #(
  parameter int HIT_PTS   = 10,
  parameter int ADDR_W    = 6,
  parameter int MAX_FRAME = 4095
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  input  logic [7:0]        keycode,
  input  logic [7:0]        keycode_second,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic [15:0]       chart_data,
  output logic [3:0]        launch,
  input  logic [3:0]        hit_evt,
  input  logic [3:0]        miss_evt,
  output logic [15:0]       score,
  output logic [7:0]        combo,
  output logic [7:0]        max_combo,
  output logic [11:0]       song_frame,
  output logic [1:0]        game_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  KEY_START = 8'h2C;
  localparam logic [7:0]  KEY_ACK   = 8'h01;
  localparam logic [7:0]  KEY_ABORT = 8'h29;
  localparam logic [11:0] FRAME_MAX = 12'(MAX_FRAME);
  localparam logic [16:0] PTS17     = 17'(HIT_PTS);

  state_t              state_q, state_d;
  logic [6:0]          outst_q, outst_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [3:0]          launch_d;
  logic [15:0]         score_d;
  logic [7:0]          combo_d, maxc_d;
  logic [11:0]         frame_d;

  // Chart entry fields; bit 14 carries nothing for this block.
  logic                entry_end;
  logic [1:0]          entry_lane;
  logic [11:0]         entry_frame;
  logic                unused_chart_bit;

  assign entry_end        = chart_data[15];
  assign entry_lane       = chart_data[13:12];
  assign entry_frame      = chart_data[11:0];
  assign unused_chart_bit = chart_data[14];

  // Either keyboard slot can carry a command key.
  logic key_start, key_ack, key_abort;
  assign key_start = (keycode == KEY_START) || (keycode_second == KEY_START);
  assign key_ack   = (keycode == KEY_ACK)   || (keycode_second == KEY_ACK);
  assign key_abort = (keycode == KEY_ABORT) || (keycode_second == KEY_ABORT);

  logic frame_at_max;
  assign frame_at_max = (song_frame == FRAME_MAX);

  // A lane reporting hit and miss together is scored as a miss only.
  logic [3:0] hit_only;
  logic [2:0] hit_cnt, miss_cnt;
  assign hit_only = hit_evt & ~miss_evt;
  assign hit_cnt  = 3'(hit_only[0]) + 3'(hit_only[1]) + 3'(hit_only[2]) + 3'(hit_only[3]);
  assign miss_cnt = 3'(miss_evt[0]) + 3'(miss_evt[1]) + 3'(miss_evt[2]) + 3'(miss_evt[3]);

  // Saturating score/combo candidates from this frame's events.
  logic [16:0] score_sum;
  logic [8:0]  combo_sum;
  logic [15:0] score_new;
  logic [7:0]  combo_new;

  // Event-derived score and combo values, independent of the game flow.
  always_comb begin
    score_sum = {1'b0, score} + (17'(hit_cnt) * PTS17);
    combo_sum = {1'b0, combo} + {6'd0, hit_cnt};
    score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    combo_new = 8'd0;
    if (miss_cnt == 3'd0) begin
      combo_new = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end
  end

  logic       launch_now;
  logic [7:0] out_up, out_down, out_diff;

  // Game flow, launch decision and outstanding-note accounting.
  always_comb begin
    state_d    = state_q;
    addr_d     = chart_addr;
    launch_d   = 4'b0000;
    score_d    = score;
    combo_d    = combo;
    maxc_d     = max_combo;
    frame_d    = song_frame;
    outst_d    = outst_q;
    launch_now = 1'b0;
    out_up     = 8'd0;
    out_down   = 8'd0;
    out_diff   = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (key_start) begin
          state_d = ST_PLAY;
          addr_d  = '0;
          frame_d = 12'd0;
          score_d = 16'd0;
          combo_d = 8'd0;
          maxc_d  = 8'd0;
          outst_d = 7'd0;
        end
      end
      ST_PLAY: begin
        frame_d = frame_at_max ? FRAME_MAX : song_frame + 12'd1;
        if (key_abort) begin
          state_d = ST_IDLE;
        end else if (entry_end || frame_at_max) begin
          // Song over: the timeout also drops any entry still pending.
          state_d = ST_DRAIN;
        end else if (song_frame >= entry_frame) begin
          launch_now = 1'b1;
          launch_d   = 4'b0001 << entry_lane;
          addr_d     = chart_addr + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        frame_d = frame_at_max ? FRAME_MAX : song_frame + 12'd1;
        if (key_abort) begin
          state_d = ST_IDLE;
        end else if (outst_q == 7'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (key_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Droppers only report while notes can be in flight.
    if ((state_q == ST_PLAY) || (state_q == ST_DRAIN)) begin
      score_d  = score_new;
      combo_d  = combo_new;
      maxc_d   = (combo_new > max_combo) ? combo_new : max_combo;
      out_up   = {1'b0, outst_q} + {7'd0, launch_now};
      out_down = {5'd0, hit_cnt} + {5'd0, miss_cnt};
      if (out_up > out_down) begin
        out_diff = out_up - out_down;
        outst_d  = out_diff[7] ? 7'h7F : out_diff[6:0];
      end else begin
        outst_d  = 7'd0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      chart_addr <= '0;
      launch     <= 4'b0000;
      score      <= 16'd0;
      combo      <= 8'd0;
      max_combo  <= 8'd0;
      song_frame <= 12'd0;
      outst_q    <= 7'd0;
    end else begin
      state_q    <= state_d;
      chart_addr <= addr_d;
      launch     <= launch_d;
      score      <= score_d;
      combo      <= combo_d;
      max_combo  <= maxc_d;
      song_frame <= frame_d;
      outst_q    <= outst_d;
    end
  end

  assign game_state = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: chart ROM model, key commands and event scoring.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
// Each task leaves the scheduler in Idle for the next one.
module tb_note_scheduler;

  logic        frame_clk;
  logic        Reset_n;
  logic [7:0]  keycode;
  logic [7:0]  keycode_second;
  logic [5:0]  chart_addr;
  logic [15:0] chart_data;
  logic [3:0]  launch;
  logic [3:0]  hit_evt;
  logic [3:0]  miss_evt;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [11:0] song_frame;
  logic [1:0]  game_state;

  logic [15:0] rom [64];
  int checks;
  int errors;

  assign chart_data = rom[chart_addr];

  note_scheduler #(.HIT_PTS(10), .ADDR_W(6), .MAX_FRAME(4095)) dut (
    .frame_clk      (frame_clk),
    .Reset_n        (Reset_n),
    .keycode        (keycode),
    .keycode_second (keycode_second),
    .chart_addr     (chart_addr),
    .chart_data     (chart_data),
    .launch         (launch),
    .hit_evt        (hit_evt),
    .miss_evt       (miss_evt),
    .score          (score),
    .combo          (combo),
    .max_combo      (max_combo),
    .song_frame     (song_frame),
    .game_state     (game_state)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h8000;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; keycode = 8'h00; keycode_second = 8'h00; hit_evt = 4'h0; miss_evt = 4'h0;
    clear_rom();
    #3;
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    checks++; if ({chart_addr, launch, score, combo, max_combo, song_frame} !== 54'd0) begin errors++; $display("FAIL reset_outputs: got nonzero output bits %h expected 0", {chart_addr, launch, score, combo, max_combo, song_frame}); end
    #4 Reset_n = 1'b1;
    tick(); tick();
    checks++; if (game_state !== 2'd0) begin errors++; $display("FAIL idle_after_reset: got %0d expected 0", game_state); end
  endtask

  task automatic test_launch();
    clear_rom();
    rom[0] = 16'h1005; rom[1] = 16'h2005; rom[2] = 16'h0009; rom[3] = 16'h8000;
    press(8'h2C);
    checks++; if (game_state !== 2'd1 || song_frame !== 12'd0) begin errors++; $display("FAIL play_entry: got state %0d frame %0d expected 1 0", game_state, song_frame); end
    repeat (5) tick();
    checks++; if (song_frame !== 12'd5 || launch !== 4'b0000) begin errors++; $display("FAIL frame5_no_launch: got frame %0d launch %b expected 5 0000", song_frame, launch); end
    tick();
    checks++; if (launch !== 4'b0010 || chart_addr !== 6'd1) begin errors++; $display("FAIL launch_lane1: got %b addr %0d expected 0010 1", launch, chart_addr); end
    tick();
    checks++; if (launch !== 4'b0100 || chart_addr !== 6'd2) begin errors++; $display("FAIL launch_lane2: got %b addr %0d expected 0100 2", launch, chart_addr); end
    tick(); tick();
    checks++; if (song_frame !== 12'd9 || launch !== 4'b0000) begin errors++; $display("FAIL frame9_wait: got frame %0d launch %b expected 9 0000", song_frame, launch); end
    tick();
    checks++; if (launch !== 4'b0001 || chart_addr !== 6'd3) begin errors++; $display("FAIL launch_lane0: got %b addr %0d expected 0001 3", launch, chart_addr); end
    tick();
    checks++; if (game_state !== 2'd2 || launch !== 4'b0000) begin errors++; $display("FAIL end_to_drain: got state %0d launch %b expected 2 0000", game_state, launch); end
  endtask

  // Continues from test_launch: Drain with three notes in flight.
  task automatic test_score();
    hit_evt = 4'b0010; tick();
    checks++; if (score !== 16'd10 || combo !== 8'd1) begin errors++; $display("FAIL hit1: got score %0d combo %0d expected 10 1", score, combo); end
    hit_evt = 4'b0100; tick();
    checks++; if (score !== 16'd20 || combo !== 8'd2 || max_combo !== 8'd2) begin errors++; $display("FAIL hit2: got score %0d combo %0d max %0d expected 20 2 2", score, combo, max_combo); end
    hit_evt = 4'b0000; miss_evt = 4'b0001; tick();
    miss_evt = 4'b0000;
    checks++; if (score !== 16'd20 || combo !== 8'd0 || max_combo !== 8'd2) begin errors++; $display("FAIL miss: got score %0d combo %0d max %0d expected 20 0 2", score, combo, max_combo); end
    tick();
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL drain_to_done: got %0d expected 3", game_state); end
    press(8'h01);
    checks++; if (game_state !== 2'd0 || score !== 16'd20 || max_combo !== 8'd2) begin errors++; $display("FAIL ack_to_idle: got state %0d score %0d max %0d expected 0 20 2", game_state, score, max_combo); end
  endtask

  task automatic test_mixed_events();
    clear_rom();
    rom[0] = 16'h0000; rom[1] = 16'h1000; rom[2] = 16'h2000;
    rom[3] = 16'h3000; rom[4] = 16'h0000; rom[5] = 16'h1000;
    press(8'h2C);
    tick();
    checks++; if (launch !== 4'b0001) begin errors++; $display("FAIL past_entry_launch: got %b expected 0001", launch); end
    repeat (6) tick();
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL six_then_drain: got %0d expected 2", game_state); end
    hit_evt = 4'b0001; tick();
    checks++; if (score !== 16'd10 || combo !== 8'd1) begin errors++; $display("FAIL mixed_pre_hit: got score %0d combo %0d expected 10 1", score, combo); end
    hit_evt = 4'b0001; miss_evt = 4'b0001; tick();
    checks++; if (score !== 16'd10 || combo !== 8'd0) begin errors++; $display("FAIL same_lane_is_miss: got score %0d combo %0d expected 10 0", score, combo); end
    hit_evt = 4'b0011; miss_evt = 4'b0100; tick();
    checks++; if (score !== 16'd30 || combo !== 8'd0) begin errors++; $display("FAIL hit_and_miss: got score %0d combo %0d expected 30 0", score, combo); end
    hit_evt = 4'b0000; miss_evt = 4'b0000; tick();
    checks++; if (game_state !== 2'd2) begin errors++; $display("FAIL one_outstanding: got state %0d expected 2", game_state); end
    hit_evt = 4'b1000; tick();
    hit_evt = 4'b0000;
    checks++; if (score !== 16'd40 || combo !== 8'd1 || max_combo !== 8'd1) begin errors++; $display("FAIL last_hit: got score %0d combo %0d max %0d expected 40 1 1", score, combo, max_combo); end
    tick();
    checks++; if (game_state !== 2'd3) begin errors++; $display("FAIL mixed_done: got %0d expected 3", game_state); end
    press(8'h01);
  endtask

  task automatic test_abort();
    clear_rom();
    rom[0] = 16'h1000; rom[1] = 16'h2003;
    press(8'h2C);
    tick();
    hit_evt = 4'b0010; tick();
    hit_evt = 4'b0000;
    tick();
    checks++; if (song_frame !== 12'd3 || score !== 16'd10 || combo !== 8'd1) begin errors++; $display("FAIL abort_setup: got frame %0d score %0d combo %0d expected 3 10 1", song_frame, score, combo); end
    keycode_second = 8'h29; tick();
    keycode_second = 8'h00;
    checks++; if (launch !== 4'b0000 || game_state !== 2'd0 || chart_addr !== 6'd1) begin errors++; $display("FAIL abort: got launch %b state %0d addr %0d expected 0000 0 1", launch, game_state, chart_addr); end
    hit_evt = 4'b1111; tick();
    hit_evt = 4'b0000; miss_evt = 4'b0001; tick();
    miss_evt = 4'b0000;
    checks++; if (score !== 16'd10 || combo !== 8'd1 || launch !== 4'b0000) begin errors++; $display("FAIL idle_events: got score %0d combo %0d launch %b expected 10 1 0000", score, combo, launch); end
  endtask

  task automatic test_timeout();
    logic launch_seen;
    launch_seen = 1'b0;
    clear_rom();
    rom[0] = 16'h3FFF;
    press(8'h2C);
    repeat (4095) begin
      tick();
      if (launch !== 4'b0000) launch_seen = 1'b1;
    end
    checks++; if (game_state !== 2'd1 || song_frame !== 12'd4095 || launch_seen !== 1'b0) begin errors++; $display("FAIL reach_max: got state %0d frame %0d launched %b expected 1 4095 0", game_state, song_frame, launch_seen); end
    tick();
    checks++; if (game_state !== 2'd2 || launch !== 4'b0000 || chart_addr !== 6'd0 || song_frame !== 12'd4095) begin errors++; $display("FAIL forced_drain: got state %0d launch %b addr %0d frame %0d expected 2 0000 0 4095", game_state, launch, chart_addr, song_frame); end
    tick();
    checks++; if (game_state !== 2'd3 || song_frame !== 12'd4095) begin errors++; $display("FAIL frame_holds: got state %0d frame %0d expected 3 4095", game_state, song_frame); end
    press(8'h01);
  endtask

  task automatic test_reset_mid_play();
    int n;
    clear_rom();
    rom[0] = 16'h0000; rom[1] = 16'h1000; rom[2] = 16'h2000; rom[3] = 16'h3064;
    press(8'h2C);
    repeat (3) tick();
    hit_evt = 4'b0001; tick();
    hit_evt = 4'b0010; tick();
    hit_evt = 4'b0100; tick();
    hit_evt = 4'b0000;
    n = 0;
    while (song_frame !== 12'd37 && n < 100) begin tick(); n++; end
    checks++; if (song_frame !== 12'd37 || combo !== 8'd3 || game_state !== 2'd1) begin errors++; $display("FAIL mid_play_setup: got frame %0d combo %0d state %0d expected 37 3 1", song_frame, combo, game_state); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (game_state !== 2'd0 || {chart_addr, launch, score, combo, max_combo, song_frame} !== 54'd0) begin errors++; $display("FAIL async_reset: got state %0d outputs %h expected 0 0", game_state, {chart_addr, launch, score, combo, max_combo, song_frame}); end
    #3 Reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (game_state !== 2'd0 || song_frame !== 12'd0) begin errors++; $display("FAIL stay_idle: got state %0d frame %0d expected 0 0", game_state, song_frame); end
    press(8'h2C);
    checks++; if (game_state !== 2'd1) begin errors++; $display("FAIL restart: got %0d expected 1", game_state); end
    press(8'h29);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_launch();
    test_score();
    test_mixed_events();
    test_abort();
    test_timeout();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Central sequencer for the per-lane arrow droppers; removes per-dropper hard-coded start-delay counters.
- Walks a chart ROM of timed note entries and issues one-cycle launch pulses to the four lane droppers.
- Collects per-lane hit/miss events back from the droppers, keeps score and combo, and runs the game flow Idle -> Play -> Drain -> Done.
- Sits between the keyboard keycode path and the dropper bank; clocked by frame_clk (one tick per video frame).

Parameters:
- HIT_PTS, 10: points added per hit event.
- ADDR_W, 6: chart ROM address width (up to 64 entries).
- MAX_FRAME, 4095: song-frame timeout; Play forces Drain when song_frame reaches this value.

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset_n  in  1  asynchronous active-low reset.
- keycode  in  8  primary keyboard keycode.
- keycode_second  in  8  secondary keyboard keycode.
- chart_addr  out  ADDR_W  chart ROM address.
- chart_data  in  16  combinational ROM read of chart_addr. Fields: [15] end flag, [13:12] lane, [11:0] launch frame. Bit 14 is ignored.
- launch  out  4  one-hot, one-cycle launch pulse per lane (0=left, 1=down, 2=up, 3=right).
- hit_evt  in  4  per-lane hit pulse from the droppers.
- miss_evt  in  4  per-lane miss pulse from the droppers.
- score  out  16  accumulated score, saturating.
- combo  out  8  current consecutive-hit count, saturating.
- max_combo  out  8  best combo this song.
- song_frame  out  12  frames elapsed since Play entry.
- game_state  out  2  0=Idle, 1=Play, 2=Drain, 3=Done.

Behaviour:
- Reset (async, Reset_n low):
  - State Idle.
  - All outputs 0: chart_addr, launch, score, combo, max_combo, song_frame.
  - Internal outstanding counter (7 bit) cleared to 0.
- "Key K pressed" means keycode==K or keycode_second==K.
- Idle:
  - Key 0x2C pressed -> Play on the next edge.
  - Same edge clears chart_addr, song_frame, score, combo, max_combo and outstanding.
  - launch stays 0 while in Idle.
- Play:
  - song_frame increments by 1 every cycle.
  - Launch rule, evaluated on registered values. If chart_data[15]==0 and song_frame >= chart_data[11:0], then on the next edge:
    - launch[chart_data[13:12]] is 1 for exactly one cycle;
    - chart_addr increments;
    - outstanding increments.
  - At most one launch per cycle. Entries sharing a launch frame go out on consecutive cycles, in ROM order.
  - Chart entries must be sorted by ascending frame. An entry whose frame is already past launches immediately.
  - chart_data[15]==1 -> Drain on the next edge, with no launch.
  - song_frame==MAX_FRAME also -> Drain. song_frame holds at MAX_FRAME from then on.
- Drain:
  - No launches.
  - song_frame keeps counting, saturating at MAX_FRAME.
  - Next edge where outstanding==0 -> Done.
- Done:
  - Outputs hold their values.
  - Key 0x01 pressed -> Idle. score and max_combo keep their values until the next Play entry.
- Abort: key 0x29 pressed in Play or Drain -> Idle on the next edge. launch is forced to 0 that cycle.
- Key precedence:
  - Abort outranks a launch in the same cycle.
  - 0x2C is ignored outside Idle.
  - 0x01 is ignored outside Done.
- Event accounting, every cycle in Play and Drain (events are ignored in Idle and Done):
  - H = popcount(hit_evt), M = popcount(miss_evt).
  - A lane asserting both hit and miss in one cycle counts as a miss only.
  - outstanding <= outstanding + launch_now - H - M, clamped at 0. Underflow is never allowed.
  - score <= min(65535, score + H*HIT_PTS).
  - If M>0, combo <= 0. Otherwise combo <= min(255, combo + H).
  - max_combo <= max(max_combo, new combo value) on the same edge.
- Latency:
  - launch and chart_addr change one edge after the launch condition holds.
  - score/combo update one edge after the event pulse.

Test Plan:
- Reset mid-Play (Reset_n low while song_frame=37, combo=3) -> immediately state 0, all outputs 0. After release, state stays Idle until 0x2C is pressed.
- Chart {lane1@5, lane2@5, lane0@9, END}, press 0x2C:
  - launch=0010 in the cycle after song_frame=5;
  - launch=0100 on the following cycle;
  - launch=0001 after song_frame=9;
  - state=2 once END is read.
- Three launches, then hits on lanes 1,2 and a miss on lane 0 in separate cycles:
  - score=20; combo 1,2, then 0; max_combo=2;
  - Drain -> Done after the third event; press 0x01 -> Idle.
- Same-cycle hit_evt=0011 and miss_evt=0100:
  - score +20, combo=0, outstanding decreases by 3.
  - Same lane both: hit_evt=0001, miss_evt=0001 -> treated as a single miss.
- Chart without an END entry whose last entry is lane3@4095:
  - forced Drain at song_frame=4095 with that note not launched;
  - song_frame stays 4095.
- Press 0x29 on the frame a launch is due -> launch stays 0 and state returns to Idle. Hit events arriving in Idle leave score and combo unchanged.
